// File: rtl/pc_reg.sv
// Program-counter register for the single-cycle RV32 core.
// Holds the current PC, loads the next-PC mux output on every rising edge,
// and derives PC+4, a misalignment flag and a post-reset valid flag from it.
module pc_reg #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,          // asynchronous, active-low
    input  logic [WIDTH-1:0] pc_prev,        // next-PC value to capture
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_misaligned,
    output logic             pc_valid
);

    // Reset vector fitted to the PC width (truncated or zero-extended).
    localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VECTOR);

    logic [WIDTH-1:0] r_pc;
    logic             r_valid;
    logic [WIDTH-1:0] w_pc_plus4;
    logic             w_misaligned;

    // PC register: loads unconditionally every edge; misaligned and X values
    // pass through untouched so the consumer sees exactly what was computed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RV;
        end else begin
            r_pc <= pc_prev;
        end
    end

    // Valid flag: cleared by reset, set by the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b1;
        end
    end

    // Derived values: PC+4 wraps modulo 2^WIDTH (carry discarded), and the
    // alignment check looks at the registered PC, not the incoming one.
    always_comb begin
        w_pc_plus4   = r_pc + WIDTH'(4);
        w_misaligned = |r_pc[1:0];
    end

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign pc_misaligned = w_misaligned;
    assign pc_valid      = r_valid;

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: two instances (default reset vector and
// 32'h8000_0000) share the same stimulus and are compared against a simple
// behavioural model of the program counter.
`timescale 1ns/1ps
module tb_pc_reg;

    logic        clk;
    logic        reset;
    logic [31:0] pc_prev;

    logic [31:0] pc_a, plus4_a;
    logic        mis_a, valid_a;
    logic [31:0] pc_b, plus4_b;
    logic        mis_b, valid_b;

    localparam logic [31:0] RV_A = 32'h0000_0000;
    localparam logic [31:0] RV_B = 32'h8000_0000;

    pc_reg #(.WIDTH(32), .RESET_VECTOR(RV_A)) dut_a (
        .clk(clk), .reset(reset), .pc_prev(pc_prev),
        .pc(pc_a), .pc_plus4(plus4_a), .pc_misaligned(mis_a), .pc_valid(valid_a)
    );

    pc_reg #(.WIDTH(32), .RESET_VECTOR(RV_B)) dut_b (
        .clk(clk), .reset(reset), .pc_prev(pc_prev),
        .pc(pc_b), .pc_plus4(plus4_b), .pc_misaligned(mis_b), .pc_valid(valid_b)
    );

    // 2 ns clock period
    initial clk = 1'b0;
    always #1 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the PC each instance should hold and its valid state.
    logic [31:0] exp_pc_a, exp_pc_b;
    bit          exp_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a.pc"},    pc_a,            exp_pc_a);
        check({tag, ".a.plus4"}, plus4_a,         exp_pc_a + 32'd4);
        check({tag, ".a.mis"},   {31'd0, mis_a},  {31'd0, (exp_pc_a % 4) != 0});
        check({tag, ".a.valid"}, {31'd0, valid_a},{31'd0, exp_valid});
        check({tag, ".b.pc"},    pc_b,            exp_pc_b);
        check({tag, ".b.plus4"}, plus4_b,         exp_pc_b + 32'd4);
        check({tag, ".b.mis"},   {31'd0, mis_b},  {31'd0, (exp_pc_b % 4) != 0});
        check({tag, ".b.valid"}, {31'd0, valid_b},{31'd0, exp_valid});
    endtask

    task automatic model_reset();
        exp_pc_a  = RV_A;
        exp_pc_b  = RV_B;
        exp_valid = 1'b0;
    endtask

    // One clock: present v, take the edge, then disturb pc_prev between
    // edges (must not matter) and check on the falling edge.
    task automatic cycle(input logic [31:0] v, input string tag);
        pc_prev = v;
        @(posedge clk);
        if (reset) begin
            exp_pc_a  = v;
            exp_pc_b  = v;
            exp_valid = 1'b1;
        end
        #0.3 pc_prev = $urandom;
        @(negedge clk);
        check_all(tag);
    endtask

    // Async reset pulse between edges, checked before any clock edge.
    task automatic async_reset(input string tag);
        reset = 1'b0;
        #0.2;
        model_reset();
        check_all(tag);
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        reset   = 1'b0;
        pc_prev = 32'h0000_0010;
        model_reset();

        // Reset held: clock toggles, outputs stay at reset values
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #0.3 pc_prev = 32'h0000_0010;
            @(negedge clk);
            check_all("reset_hold");
        end

        // Release between edges, then sequential load 0, 4, 8
        reset = 1'b1;
        cycle(32'h0000_0000, "load0");
        cycle(32'h0000_0004, "load4");
        cycle(32'h0000_0008, "load8");
        for (int i = 0; i < 6; i++) cycle(32'h0000_0008, "hold8");

        // Asynchronous reset mid-run
        cycle(32'h0000_0100, "load100");
        async_reset("async_rst");
        pc_prev = 32'h0000_0020;
        @(posedge clk);
        #0.3;
        @(negedge clk);
        check_all("rst_low_edge");
        reset = 1'b1;
        cycle(32'h0000_0020, "after_rst");

        // Wrap-around and misalignment
        cycle(32'hFFFF_FFFC, "wrap");
        cycle(32'h0000_0006, "misaligned");
        cycle(32'h0000_0008, "realigned");
        cycle(32'hFFFF_FFFF, "wrap_mis");

        // Randomized run with occasional asynchronous resets
        for (int i = 0; i < 300; i++) begin
            v = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                async_reset("rnd_rst");
                cycle(v, "rnd_rst_low");
                reset = 1'b1;
            end else begin
                cycle(v, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_reg.md
Name: pc_reg

Overview:
- Program-counter register for the single-cycle RV32 core.
- Captures the next-PC value computed by the fetch/branch logic on every rising clock edge and presents it as the current PC to instruction memory and the PC adder.
- Also provides PC+4, an alignment flag and a post-reset valid flag, so downstream fetch logic needs no extra registers.

Parameters:
- WIDTH, 32, bit width of the PC and all PC-valued ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded while reset is asserted (truncated/zero-extended to WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- pc_prev  input  WIDTH  next-PC value to be registered (output of next-PC mux).
- pc  output  WIDTH  current registered PC.
- pc_plus4  output  WIDTH  pc + 4, combinational from pc.
- pc_misaligned  output  1  high when pc[1:0] != 2'b00.
- pc_valid  output  1  low during reset and until the first rising edge after reset release; high thereafter.

Behaviour:
- One clock, one asynchronous active-low reset. No other control inputs; the register loads every cycle (no enable, no stall). Only clk, reset and pc_prev are required connections; all outputs may be left open.
- Reset assertion (reset=0), at any time, takes effect immediately and independent of clk:
  - pc = RESET_VECTOR
  - pc_valid = 0
  - pc_plus4 = RESET_VECTOR+4
  - pc_misaligned = |RESET_VECTOR[1:0]
- Reset held low: outputs stay at reset values regardless of clk or pc_prev.
- Reset mid-operation: pc returns to RESET_VECTOR asynchronously; the previously loaded value is lost.
- Normal operation (reset=1): on each rising clk edge, pc <= pc_prev. Latency is exactly one edge, no pipelining. pc_prev changes between edges do not affect pc.
- Reset release: the first rising edge with reset=1 loads pc_prev and sets pc_valid=1. pc_valid stays 1 until the next reset.
- pc_prev must be X-free at each capturing edge. X/Z on pc_prev propagates to pc; no filtering.
- pc_plus4:
  - Purely combinational, modulo 2^WIDTH.
  - Wraps at the top: pc = 32'hFFFF_FFFC gives pc_plus4 = 32'h0000_0000.
  - No carry-out.
- pc_misaligned:
  - Combinational from the registered pc, not from pc_prev.
  - The register still loads misaligned values unchanged; trap handling is the consumer's job.
- Clock idle with reset=1: pc holds indefinitely.
- No internal state other than the pc register and the pc_valid flop.

Test Plan:
- Reset: hold reset=0, toggle clk with pc_prev=32'h0000_0010 → pc stays 32'h0000_0000, pc_valid=0, pc_plus4=32'h0000_0004.
- Sequential load: clk period 2 ns, reset=1; drive pc_prev 32'h0, then 32'h4 at t=2 ns, then 32'h8 at t=4 ns → pc follows each value on the next rising edge, ends at 32'h0000_0008 and holds through t=20 ns. pc_plus4=32'h0000_000C, pc_valid=1.
- Asynchronous reset mid-run: pc=32'h0000_0100, drop reset between edges → pc=32'h0 immediately, without a clock edge. Release reset with pc_prev=32'h20 → pc=32'h20 on the next edge.
- Wrap-around: load pc_prev=32'hFFFF_FFFC → pc=32'hFFFF_FFFC, pc_plus4=32'h0000_0000.
- Misalignment: load pc_prev=32'h0000_0006 → pc=32'h6, pc_misaligned=1. Next load of 32'h8 → pc_misaligned=0.
- Non-default parameter: RESET_VECTOR=32'h8000_0000 → pc=32'h8000_0000 during reset, pc_plus4=32'h8000_0004.
